// File: rtl/polygon_pkg.sv
// Shared types and constants for the polygon vertex loader and its helpers.
package polygon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PENDING = 2'd2
    } loader_state_t;

    localparam int unsigned MIN_VERTICES = 3;

endpackage

// File: rtl/polygon_bbox_tracker.sv
// Running signed min/max of a vertex stream; instantiated by polygon_vertex_loader
// only when POLYGON_LOADER_BBOX_EN is defined.
module polygon_bbox_tracker #(
    parameter int unsigned COORD_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init,
    input  logic                          update,
    input  logic                          clear,
    input  logic signed [COORD_WIDTH-1:0] x,
    input  logic signed [COORD_WIDTH-1:0] y,
    output logic signed [COORD_WIDTH-1:0] xmin,
    output logic signed [COORD_WIDTH-1:0] xmax,
    output logic signed [COORD_WIDTH-1:0] ymin,
    output logic signed [COORD_WIDTH-1:0] ymax
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            xmin <= '0;
            xmax <= '0;
            ymin <= '0;
            ymax <= '0;
        end else if (init) begin
            xmin <= x;
            xmax <= x;
            ymin <= y;
            ymax <= y;
        end else if (update) begin
            if (x < xmin) xmin <= x;
            if (x > xmax) xmax <= x;
            if (y < ymin) ymin <= y;
            if (y > ymax) ymax <= y;
        end
    end

endmodule

// File: rtl/polygon_vertex_loader.sv
// Collects polygon vertices into a shadow buffer and commits them on a frame pulse.
// Optional bounding-box outputs are enabled by defining POLYGON_LOADER_BBOX_EN.
module polygon_vertex_loader
    import polygon_pkg::*;
#(
    parameter int unsigned MAX_NUM_VERTICES = 4,
    parameter int unsigned COORD_WIDTH      = 32
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic signed [COORD_WIDTH-1:0]       vtx_x_in,
    input  logic signed [COORD_WIDTH-1:0]       vtx_y_in,
    input  logic                                vtx_last_in,
    input  logic                                vtx_valid_in,
    output logic                                vtx_ready_out,
    input  logic                                new_frame_in,
    output logic signed [COORD_WIDTH-1:0]       xs_out [MAX_NUM_VERTICES],
    output logic signed [COORD_WIDTH-1:0]       ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES):0]   num_points_out,
    output logic                                poly_valid_out,
    output logic                                err_short_out,
    output logic                                err_overflow_out
`ifdef POLYGON_LOADER_BBOX_EN
    ,
    output logic signed [COORD_WIDTH-1:0]       bbox_xmin_out,
    output logic signed [COORD_WIDTH-1:0]       bbox_xmax_out,
    output logic signed [COORD_WIDTH-1:0]       bbox_ymin_out,
    output logic signed [COORD_WIDTH-1:0]       bbox_ymax_out
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_NUM_VERTICES) + 1;
    localparam int unsigned IDX_W = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;

    loader_state_t state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic signed [COORD_WIDTH-1:0] shadow_x [MAX_NUM_VERTICES];
    logic signed [COORD_WIDTH-1:0] shadow_y [MAX_NUM_VERTICES];

    logic             xfer_c, full_c, last_xfer_c, short_c, ovf_err_c, good_last_c;
    logic [CNT_W-1:0] beat_count_c;
    logic             shadow_wr_c, commit_c;
    logic [IDX_W-1:0] shadow_idx_c;

    // Count and overflow status as they stand after the current beat.
    assign xfer_c       = vtx_valid_in && vtx_ready_out;
    assign full_c       = (count_q == CNT_W'(MAX_NUM_VERTICES));
    assign beat_count_c = (state_q == IDLE) ? CNT_W'(1)
                        : (full_c ? count_q : count_q + CNT_W'(1));
    assign last_xfer_c  = xfer_c && vtx_last_in;
    assign short_c      = last_xfer_c && (beat_count_c < CNT_W'(MIN_VERTICES));
    assign ovf_err_c    = last_xfer_c && !short_c && (state_q == COLLECT) && (ovf_q || full_c);
    assign good_last_c  = last_xfer_c && !short_c && !ovf_err_c;

    always_ff @(posedge clk_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer_c) state_d = good_last_c ? PENDING : (vtx_last_in ? IDLE : COLLECT);
            COLLECT: if (last_xfer_c) state_d = good_last_c ? PENDING : IDLE;
            PENDING: if (new_frame_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shadow_wr_c  = 1'b0;
        shadow_idx_c = '0;
        commit_c     = 1'b0;
        case (state_q)
            IDLE:    shadow_wr_c = xfer_c;
            COLLECT: begin
                shadow_wr_c  = xfer_c && !full_c;
                shadow_idx_c = IDX_W'(count_q);
            end
            PENDING: commit_c = new_frame_in;
            default: ;
        endcase
    end

    // Shadow collection, commit into the frame-stable arrays, and status pulses.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count_q          <= '0;
            ovf_q            <= 1'b0;
            vtx_ready_out    <= 1'b0;
            num_points_out   <= '0;
            poly_valid_out   <= 1'b0;
            err_short_out    <= 1'b0;
            err_overflow_out <= 1'b0;
            for (int i = 0; i < int'(MAX_NUM_VERTICES); i++) begin
                shadow_x[i] <= '0;
                shadow_y[i] <= '0;
                xs_out[i]   <= '0;
                ys_out[i]   <= '0;
            end
        end else begin
            vtx_ready_out    <= (state_d != PENDING);
            err_short_out    <= short_c;
            err_overflow_out <= ovf_err_c;
            ovf_q            <= (state_d == COLLECT) &&
                                (ovf_q || (xfer_c && full_c && state_q == COLLECT));
            if (state_d == IDLE)  count_q <= '0;
            else if (xfer_c)      count_q <= beat_count_c;
            if (shadow_wr_c) begin
                shadow_x[shadow_idx_c] <= vtx_x_in;
                shadow_y[shadow_idx_c] <= vtx_y_in;
            end
            if (commit_c) begin
                num_points_out <= count_q;
                poly_valid_out <= 1'b1;
                for (int i = 0; i < int'(MAX_NUM_VERTICES); i++) begin
                    xs_out[i] <= (CNT_W'(i) < count_q) ? shadow_x[i] : '0;
                    ys_out[i] <= (CNT_W'(i) < count_q) ? shadow_y[i] : '0;
                end
            end
        end
    end

`ifdef POLYGON_LOADER_BBOX_EN
    logic signed [COORD_WIDTH-1:0] trk_xmin, trk_xmax, trk_ymin, trk_ymax;

    polygon_bbox_tracker #(
        .COORD_WIDTH (COORD_WIDTH)
    ) u_bbox (
        .clk    (clk_in),
        .rst_n  (rst_in),
        .init   (xfer_c && (state_q == IDLE)),
        .update (shadow_wr_c && (state_q == COLLECT)),
        .clear  (short_c || ovf_err_c),
        .x      (vtx_x_in),
        .y      (vtx_y_in),
        .xmin   (trk_xmin),
        .xmax   (trk_xmax),
        .ymin   (trk_ymin),
        .ymax   (trk_ymax)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bbox_xmin_out <= '0;
            bbox_xmax_out <= '0;
            bbox_ymin_out <= '0;
            bbox_ymax_out <= '0;
        end else if (commit_c) begin
            bbox_xmin_out <= trk_xmin;
            bbox_xmax_out <= trk_xmax;
            bbox_ymin_out <= trk_ymin;
            bbox_ymax_out <= trk_ymax;
        end
    end
`endif

endmodule
